le_regiao: RTL and testbench

Reads a square region of the framebuffer back out as a raster-ordered pixel stream. It is the read-side counterpart of the cursor painter. Given an origin and a size, it walks the (size+1)×(size+1) square, issuing reads to the framebuffer RAM's fixed-latency read port. It clips coordinates that fall outside the screen and delivers each pixel, with its coordinates, over a valid/ready stream. Used for saving the background under the cursor and for read-back/export.

---
 rtl/pinta_pkg.sv | 34 +++
 rtl/le_regiao_if.sv | 35 +++
 rtl/le_regiao_fifo_pixel.sv | 58 +++++
 rtl/le_regiao.sv | 174 +++++++++++++++++
 tb/tb_le_regiao.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pinta_pkg.sv
// Shared framebuffer constants, FSM state encoding and pixel record layout.
// Latency: none, declarations only.
// Backpressure: not applicable.
package pinta_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int COORD_W   = 11;
    localparam int PIX_W     = 8;
    localparam int SIZE_W    = 7;
    localparam int FB_ADDR_W = 19;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    // Coordinates and end-of-square marker travelling alongside a read
    typedef struct packed {
        logic               last;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } tag_t;

    // One stream beat: {last, y, x, data}
    typedef struct packed {
        tag_t             tag;
        logic [PIX_W-1:0] data;
    } pix_t;

    // Linear framebuffer address, rows of H_RES pixels; shared with the painter
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [COORD_W-1:0] y,
                                                     input logic [COORD_W-1:0] x);
        return FB_ADDR_W'(y) * FB_ADDR_W'(H_RES) + FB_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/le_regiao_if.sv
// Bundles the request, RAM read port and pixel stream of the region reader.
// Latency: none, wiring only.
// Backpressure: pix_ready from the consumer, carried as a plain signal.
interface le_regiao_if #(parameter int ADDR_W = 19) ();
    import pinta_pkg::*;

    logic                start;
    logic [COORD_W-1:0]  x_origin;
    logic [COORD_W-1:0]  y_origin;
    logic [SIZE_W-1:0]   size;
    logic                busy;
    logic                done;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [PIX_W-1:0]    mem_data;
    logic                pix_valid;
    logic                pix_ready;
    logic [PIX_W-1:0]    pix_data;
    logic [COORD_W-1:0]  pix_x;
    logic [COORD_W-1:0]  pix_y;
    logic                pix_last;

    // The region reader itself
    modport master (
        input  start, x_origin, y_origin, size, mem_data, pix_ready,
        output busy, done, mem_rd, mem_addr, pix_valid, pix_data, pix_x, pix_y, pix_last
    );

    // Requester, RAM and stream consumer
    modport slave (
        output start, x_origin, y_origin, size, mem_data, pix_ready,
        input  busy, done, mem_rd, mem_addr, pix_valid, pix_data, pix_x, pix_y, pix_last
    );

endinterface

// File: rtl/le_regiao_fifo_pixel.sv
// Synchronous FIFO of pixel beats with an occupancy count for credit checks.
// Latency: a write is visible at the head the cycle after it is taken.
// Backpressure: none internally; the writer must respect count against DEPTH.
module fifo_pixel
    import pinta_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  pix_t          wr_dat,
    input  logic          rd_en,
    output pix_t          rd_dat,
    output logic          empty,
    output logic [CW-1:0] count
);

    pix_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage array, written on every accepted beat
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers and occupancy; reset empties the queue
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_next(wr_ptr);
            if (rd_en) rd_ptr <= ptr_next(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_dat = mem[rd_ptr];
    assign empty  = (cnt == '0);
    assign count  = cnt;

endmodule

// File: rtl/le_regiao.sv
// Walks a (size+1)^2 square of the framebuffer, reads in-bounds pixels, streams them raster-ordered.
// Latency: first read the cycle after start, first pixel RD_LAT+2 cycles after start.
// Backpressure: reads issue only while in-flight reads plus queued pixels < RD_LAT+2.
module le_regiao
    import pinta_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 19
) (
    input  logic       clock,
    input  logic       reset,
    le_regiao_if.master bus
);

    localparam int          DEPTH = RD_LAT + 2;
    localparam int          CW    = $clog2(DEPTH + 1);
    localparam logic [11:0] X_MAX = 12'(H_RES - 1);
    localparam logic [11:0] Y_MAX = 12'(V_RES - 1);

    state_t              state_q, state_d;
    logic                done_q, done_d;
    logic                accept, step, mem_rd;
    logic [11:0]         x0, x_lim, y_lim, x_end, y_end, cur_x, cur_y;
    logic [11:0]         x_span, y_span;
    logic                clipped, at_x_lim, at_y_lim, credit_ok;
    tag_t                tag_pipe [RD_LAT];
    logic [RD_LAT-1:0]   tag_vld;
    logic [CW-1:0]       out_cnt, fifo_cnt;
    logic                fifo_empty, fifo_wr, pop;
    pix_t                wr_dat, head;

    // 12-bit sums so origin+size never wraps
    assign x_span    = {1'b0, bus.x_origin} + 12'(bus.size);
    assign y_span    = {1'b0, bus.y_origin} + 12'(bus.size);
    assign clipped   = (cur_x >= 12'(H_RES)) || (cur_y >= 12'(V_RES));
    assign at_x_lim  = (cur_x == x_lim);
    assign at_y_lim  = (cur_y == y_lim);
    assign credit_ok = ({1'b0, out_cnt} + {1'b0, fifo_cnt}) < (CW + 1)'(DEPTH);

    // State and completion pulse registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next state, read strobe and walk step
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        step    = 1'b0;
        mem_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (clipped) begin
                    step = 1'b1;
                end else if (credit_ok) begin
                    mem_rd = 1'b1;
                    step   = 1'b1;
                end
                if (step && at_x_lim && at_y_lim) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_cnt == '0 && fifo_empty) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture and raster walk: x first, wrap to origin then y
    always_ff @(posedge clock) begin
        if (!reset) begin
            x0    <= '0;
            x_lim <= '0;
            y_lim <= '0;
            x_end <= '0;
            y_end <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else if (accept) begin
            x0    <= {1'b0, bus.x_origin};
            x_lim <= x_span;
            y_lim <= y_span;
            x_end <= (x_span > X_MAX) ? X_MAX : x_span;
            y_end <= (y_span > Y_MAX) ? Y_MAX : y_span;
            cur_x <= {1'b0, bus.x_origin};
            cur_y <= {1'b0, bus.y_origin};
        end else if (step) begin
            if (at_x_lim) begin
                cur_x <= x0;
                cur_y <= cur_y + 1'b1;
            end else begin
                cur_x <= cur_x + 1'b1;
            end
        end
    end

    // Tag valid bits; clearing them discards any RAM data still in flight
    always_ff @(posedge clock) begin
        if (!reset) begin
            tag_vld <= '0;
        end else begin
            tag_vld[0] <= mem_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
            end
        end
    end

    // Tag payload rides beside the read; only meaningful where tag_vld is set
    always_ff @(posedge clock) begin
        tag_pipe[0] <= '{last: (cur_x == x_end) && (cur_y == y_end),
                         y:    cur_y[COORD_W-1:0],
                         x:    cur_x[COORD_W-1:0]};
        for (int i = 1; i < RD_LAT; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Reads in flight between strobe and FIFO write
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_cnt <= '0;
        end else begin
            case ({mem_rd, fifo_wr})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    assign fifo_wr = tag_vld[RD_LAT-1];
    assign wr_dat  = '{tag: tag_pipe[RD_LAT-1], data: bus.mem_data};
    assign pop     = !fifo_empty && bus.pix_ready;

    fifo_pixel #(.DEPTH(DEPTH)) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (fifo_wr),
        .wr_dat (wr_dat),
        .rd_en  (pop),
        .rd_dat (head),
        .empty  (fifo_empty),
        .count  (fifo_cnt)
    );

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_addr  = mem_rd ? ADDR_W'(fb_addr(cur_y[COORD_W-1:0], cur_x[COORD_W-1:0])) : '0;
    assign bus.pix_valid = !fifo_empty;
    assign bus.pix_data  = fifo_empty ? '0 : head.data;
    assign bus.pix_x     = fifo_empty ? '0 : head.tag.x;
    assign bus.pix_y     = fifo_empty ? '0 : head.tag.y;
    assign bus.pix_last  = fifo_empty ? 1'b0 : head.tag.last;

endmodule

// File: tb/tb_le_regiao.sv
// Directed bench for the region reader: RAM model, scoreboard on reads and stream beats.
// Latency: checks first-read, first-pixel and done timing against the start edge.
// Backpressure: pseudo-random pix_ready in the large-square case.
module tb_le_regiao;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    le_regiao_if #(.ADDR_W(19)) bus ();

    le_regiao #(.RD_LAT(2), .ADDR_W(19)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Bench-side RAM contents: a fixed hash of the address
    function automatic logic [7:0] fpix(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]};
    endfunction

    function automatic logic [18:0] addr_of(input logic [22:0] e);
        return 19'(e[21:11]) * 19'd640 + 19'(e[10:0]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Two-cycle RAM read model
    logic [7:0] p0, p1;
    always @(posedge clock) begin
        p0 <= bus.mem_rd ? fpix(bus.mem_addr) : 8'hEE;
        p1 <= p0;
    end
    assign bus.mem_data = p1;

    // Cycle counter; remembers the edge that accepted a start
    int cyc = 0;
    int st_cyc = 0;
    always @(posedge clock) begin
        if (bus.start && !bus.busy && reset) st_cyc <= cyc + 1;
        cyc <= cyc + 1;
    end

    bit rnd_ready = 1'b0;
    always @(posedge clock) begin
        #2;
        bus.pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard state
    logic [22:0] exp_q[$];
    int rd_n, px_n, done_n, vld_n, first_rd, first_v, last_c, done_c, max_infl;
    bit prev_v = 1'b0, prev_r = 1'b0;
    logic [30:0] prev_pix = '0;

    // Monitor sampled mid-cycle
    always @(negedge clock) begin
        logic [30:0] pix;
        pix = {bus.pix_last, bus.pix_y, bus.pix_x, bus.pix_data};
        if (bus.mem_rd) begin
            if (first_rd < 0) first_rd = cyc - st_cyc + 1;
            if (rd_n < exp_q.size()) chk("rd_addr", 64'(bus.mem_addr), 64'(addr_of(exp_q[rd_n])));
            else chk("extra_rd", 64'(rd_n), 64'(exp_q.size()));
            rd_n++;
        end
        if (bus.pix_valid) begin
            vld_n++;
            if (first_v < 0) first_v = cyc - st_cyc + 1;
        end
        if (prev_v && !prev_r) chk("hold", 64'({bus.pix_valid, pix}), 64'({1'b1, prev_pix}));
        if (bus.pix_valid && bus.pix_ready) begin
            if (px_n < exp_q.size())
                chk("pix", 64'(pix), 64'({exp_q[px_n], fpix(addr_of(exp_q[px_n]))}));
            else chk("extra_pix", 64'(px_n), 64'(exp_q.size()));
            px_n++;
            last_c = cyc - st_cyc + 1;
        end
        if (bus.done) begin
            done_n++;
            done_c = cyc - st_cyc + 1;
        end
        if (rd_n - px_n > max_infl) max_infl = rd_n - px_n;
        prev_v = bus.pix_valid;
        prev_r = bus.pix_ready;
        prev_pix = pix;
    end

    function automatic logic [63:0] outs();
        return 64'({bus.busy, bus.done, bus.mem_rd, bus.mem_addr, bus.pix_valid,
                    bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last});
    endfunction

    // Build the expected raster list and clear the counters
    task automatic arm(input int x0, input int y0, input int sz);
        logic [22:0] t;
        exp_q.delete();
        for (int yy = y0; yy <= y0 + sz; yy++)
            for (int xx = x0; xx <= x0 + sz; xx++)
                if (xx < 640 && yy < 480) exp_q.push_back({1'b0, 11'(yy), 11'(xx)});
        if (exp_q.size() > 0) begin
            t = exp_q.pop_back();
            t[22] = 1'b1;
            exp_q.push_back(t);
        end
        rd_n = 0; px_n = 0; done_n = 0; vld_n = 0;
        first_rd = -1; first_v = -1; last_c = -1; done_c = -1; max_infl = 0;
    endtask

    task automatic go(input int x0, input int y0, input int sz);
        @(negedge clock); #1;
        bus.start = 1'b1;
        bus.x_origin = 11'(x0);
        bus.y_origin = 11'(y0);
        bus.size = 7'(sz);
        @(negedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit && done_n == 0; i++) begin
            @(negedge clock); #1;
        end
        if (done_n == 0) chk({tag, "_timeout"}, 64'(done_n), 64'd1);
        repeat (3) @(negedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;
        bus.x_origin = '0;
        bus.y_origin = '0;
        bus.size = '0;
        arm(700, 700, 0);
        repeat (3) @(negedge clock);
        #1;
        chk("reset_outs", outs(), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // 3x3 square fully on screen
        arm(10, 20, 2);
        go(10, 20, 2);
        wait_done("t1", 200);
        chk("t1_reads", 64'(rd_n), 64'd9);
        chk("t1_pixels", 64'(px_n), 64'd9);
        chk("t1_first_rd", 64'(first_rd), 64'd1);
        chk("t1_first_valid", 64'(first_v), 64'd4);
        chk("t1_done_count", 64'(done_n), 64'd1);
        chk("t1_done_after_last", 64'((done_c - last_c == 1) || (done_c - last_c == 2)), 64'd1);
        chk("t1_busy_low", 64'(bus.busy), 64'd0);

        // Bottom-right corner, mostly clipped
        arm(638, 479, 3);
        go(638, 479, 3);
        wait_done("t2", 200);
        chk("t2_reads", 64'(rd_n), 64'd2);
        chk("t2_pixels", 64'(px_n), 64'd2);

        // Origin off screen
        arm(700, 10, 2);
        go(700, 10, 2);
        wait_done("t3", 200);
        chk("t3_reads", 64'(rd_n), 64'd0);
        chk("t3_valid_cycles", 64'(vld_n), 64'd0);
        chk("t3_done_count", 64'(done_n), 64'd1);
        chk("t3_busy_low", 64'(bus.busy), 64'd0);

        // Largest square under random backpressure
        rnd_ready = 1'b1;
        arm(100, 100, 127);
        go(100, 100, 127);
        wait_done("t4", 60000);
        rnd_ready = 1'b0;
        chk("t4_reads", 64'(rd_n), 64'd16384);
        chk("t4_pixels", 64'(px_n), 64'd16384);
        chk("t4_inflight_le4", 64'(max_infl <= 4), 64'd1);
        chk("t4_done_count", 64'(done_n), 64'd1);

        // Reset in mid-scan, then a single-pixel request
        arm(50, 60, 20);
        go(50, 60, 20);
        repeat (8) @(negedge clock);
        #1;
        reset = 1'b0;
        arm(700, 700, 0);
        @(negedge clock); #1;
        chk("t5_mid_reset_outs", outs(), 64'd0);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        #1;
        chk("t5_no_done", 64'(done_n), 64'd0);
        chk("t5_no_late_pixel", 64'(px_n), 64'd0);
        chk("t5_no_read", 64'(rd_n), 64'd0);
        arm(5, 5, 0);
        go(5, 5, 0);
        wait_done("t5b", 200);
        chk("t5_single_pixels", 64'(px_n), 64'd1);
        chk("t5_single_done", 64'(done_n), 64'd1);

        // Second start while busy is ignored
        arm(30, 40, 3);
        go(30, 40, 3);
        repeat (2) @(negedge clock);
        go(200, 200, 3);
        wait_done("t6", 300);
        chk("t6_reads", 64'(rd_n), 64'd16);
        chk("t6_pixels", 64'(px_n), 64'd16);
        chk("t6_done_count", 64'(done_n), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
